// File: rtl/xor_decoder_pkg.sv
// Shared constants and helpers for the xor_decoder slice.
// Optional parity accumulator in the top is enabled by XOR_DECODER_PARITY_EN.
package xor_decoder_pkg;

    localparam int unsigned WIDTH_MIN = 1;
    localparam int unsigned WIDTH_MAX = 64;

    // Bits needed to hold the values 0..width inclusive, i.e. $clog2(width+1).
    function automatic int unsigned calc_cw(input int unsigned width);
        int unsigned cw;
        cw = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < (64'(width) + 64'd1)) begin
                cw = i + 1;
            end
        end
        return cw;
    endfunction

endpackage

// File: rtl/xor_decoder_stage.sv
// Combinational compare stage: bitwise xor/xnor, equality and popcount of the difference.
// Parity option (XOR_DECODER_PARITY_EN) lives in the top; this stage is unaffected by it.
module xor_decoder_stage
    import xor_decoder_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CW    = calc_cw(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] xor_bits,
    output logic [WIDTH-1:0] xnor_bits,
    output logic             eq,
    output logic [CW-1:0]    cnt
);

    always_comb begin
        xor_bits  = a ^ b;
        xnor_bits = ~(a ^ b);
        eq        = ~|(a ^ b);
    end

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt = cnt + CW'(xor_bits[i]);
        end
    end

endmodule

// File: rtl/xor_decoder.sv
// Registered XOR/XNOR decoder with equality flag and differing-bit count, 1-cycle latency.
// Define XOR_DECODER_PARITY_EN to add the clr input and the running parity_o accumulator.
module xor_decoder
    import xor_decoder_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
`ifdef XOR_DECODER_PARITY_EN
    input  logic                       clr,
    output logic                       parity_o,
`endif
    output logic [WIDTH-1:0]           xor_o,
    output logic [WIDTH-1:0]           xnor_o,
    output logic                       eq_o,
    output logic [$clog2(WIDTH+1)-1:0] diff_cnt,
    output logic                       out_valid
);

    localparam int unsigned CW = calc_cw(WIDTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("xor_decoder: WIDTH must be within 1..64");
    end

    logic [WIDTH-1:0] xor_bits;
    logic [WIDTH-1:0] xnor_bits;
    logic             eq;
    logic [CW-1:0]    cnt;

    xor_decoder_stage #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_stage (
        .a         (a),
        .b         (b),
        .xor_bits  (xor_bits),
        .xnor_bits (xnor_bits),
        .eq        (eq),
        .cnt       (cnt)
    );

    // Result registers only load on accepted inputs, so X on idle operands never propagates.
    always_ff @(posedge clk) begin
        if (rst) begin
            xor_o     <= '0;
            xnor_o    <= '1;
            eq_o      <= 1'b1;
            diff_cnt  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                xor_o    <= xor_bits;
                xnor_o   <= xnor_bits;
                eq_o     <= eq;
                diff_cnt <= cnt;
            end
        end
    end

`ifdef XOR_DECODER_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            parity_o <= 1'b0;
        end else if (in_valid) begin
            parity_o <= parity_o ^ (^xor_bits);
        end
    end
`endif

endmodule

// File: tb/tb_xor_decoder.sv
// Scoreboard bench for xor_decoder: WIDTH=1 and WIDTH=8 instances, plus WIDTH=4 parity
// instance when XOR_DECODER_PARITY_EN is defined.
module tb_xor_decoder;

    typedef struct {
        logic [7:0] x;
        logic [7:0] xn;
        logic       e;
        logic [3:0] c;
    } exp_t;

    logic       clk;
    logic       rst;

    logic       v1, ov1, e1;
    logic [0:0] a1, b1, x1, xn1, c1;

    logic       v8, ov8, e8;
    logic [7:0] a8, b8, x8, xn8;
    logic [3:0] c8;

`ifdef XOR_DECODER_PARITY_EN
    logic       v4, ov4, e4, clr4, p4;
    logic [3:0] a4, b4, x4, xn4;
    logic [2:0] c4;
`endif

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t q[2][$];
    exp_t last[2];
    bit   pend[2];

    xor_decoder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1),
`ifdef XOR_DECODER_PARITY_EN
        .clr(1'b0), .parity_o(),
`endif
        .xor_o(x1), .xnor_o(xn1), .eq_o(e1), .diff_cnt(c1), .out_valid(ov1)
    );

    xor_decoder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8),
`ifdef XOR_DECODER_PARITY_EN
        .clr(1'b0), .parity_o(),
`endif
        .xor_o(x8), .xnor_o(xn8), .eq_o(e8), .diff_cnt(c8), .out_valid(ov8)
    );

`ifdef XOR_DECODER_PARITY_EN
    xor_decoder #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4),
        .clr(clr4), .parity_o(p4),
        .xor_o(x4), .xnor_o(xn4), .eq_o(e4), .diff_cnt(c4), .out_valid(ov4)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] mask_of(input int w);
        return 8'((9'd1 << w) - 9'd1);
    endfunction

    function automatic logic [3:0] pop8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int w);
        exp_t r;
        r.x  = (a ^ b) & mask_of(w);
        r.xn = ~(a ^ b) & mask_of(w);
        r.e  = (r.x == 8'h00);
        r.c  = pop8(r.x);
        return r;
    endfunction

    function automatic exp_t rst_val(input int w);
        exp_t r;
        r.x  = 8'h00;
        r.xn = mask_of(w);
        r.e  = 1'b1;
        r.c  = 4'd0;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // u=0 drives the WIDTH=1 instance, u=1 the WIDTH=8 instance.
    task automatic drive_unit(input int u, input logic v, input logic [7:0] a, input logic [7:0] b);
        int w;
        w = (u == 0) ? 1 : 8;
        if (u == 0) begin
            v1 = v; a1 = a[0:0]; b1 = b[0:0];
        end else begin
            v8 = v; a8 = a; b8 = b;
        end
        if (rst === 1'b1) begin
            pend[u] = 1'b0;
            q[u].delete();
            last[u] = rst_val(w);
        end else begin
            pend[u] = (v === 1'b1);
            if (pend[u]) q[u].push_back(model(a, b, w));
        end
    endtask

    task automatic check_unit(input int u, input string tag);
        logic       ov, e;
        logic [7:0] x, xn;
        logic [3:0] c;
        logic [7:0] m;
        m = mask_of((u == 0) ? 1 : 8);
        if (u == 0) begin
            ov = ov1; x = {7'b0, x1}; xn = {7'b0, xn1}; e = e1; c = {3'b0, c1};
        end else begin
            ov = ov8; x = x8; xn = xn8; e = e8; c = c8;
        end
        chk({tag, ".valid"}, 64'(ov), 64'(pend[u]));
        if (ov === 1'b1 && q[u].size() > 0) last[u] = q[u].pop_front();
        chk({tag, ".xor"},  64'(x),  64'(last[u].x));
        chk({tag, ".xnor"}, 64'(xn), 64'(last[u].xn));
        chk({tag, ".eq"},   64'(e),  64'(last[u].e));
        chk({tag, ".cnt"},  64'(c),  64'(last[u].c));
        chk({tag, ".inv_xnor"}, 64'(xn), 64'(~x & m));
        chk({tag, ".inv_eq"},   64'(e),  64'(x == 8'h00));
        chk({tag, ".inv_cnt"},  64'(c),  64'(pop8(x)));
    endtask

    initial begin
        logic [1:0] pat [4];
        logic       exp_x1 [4];

        pat    = '{2'b00, 2'b10, 2'b01, 2'b11};
        exp_x1 = '{1'b0, 1'b1, 1'b1, 1'b0};

        // Reset cycle with an input presented: must be discarded.
        rst = 1'b1;
        drive_unit(0, 1'b1, 8'h01, 8'h00);
        drive_unit(1, 1'b1, 8'h01, 8'h00);
`ifdef XOR_DECODER_PARITY_EN
        v4 = 1'b1; a4 = 4'h1; b4 = 4'h0; clr4 = 1'b1;
`endif
        tick;
        check_unit(0, "reset_w1");
        check_unit(1, "reset_w8");
        chk("reset_w1.xnor_lit", 64'(xn1), 64'd1);
`ifdef XOR_DECODER_PARITY_EN
        chk("reset_w4.parity", 64'(p4), 64'd0);
        v4 = 1'b0; clr4 = 1'b0;
`endif
        rst = 1'b0;

        // WIDTH=1 truth table, back to back; WIDTH=8 idle must hold reset values.
        for (int i = 0; i < 4; i++) begin
            drive_unit(0, 1'b1, {7'b0, pat[i][1]}, {7'b0, pat[i][0]});
            drive_unit(1, 1'b0, 8'h00, 8'h00);
            tick;
            check_unit(0, $sformatf("w1_tt%0d", i));
            check_unit(1, $sformatf("w8_idle%0d", i));
            chk($sformatf("w1_tt%0d.xor_lit", i), 64'(x1), 64'(exp_x1[i]));
        end

        // All bits differ, then idle with X operands: values must hold.
        drive_unit(0, 1'b0, 8'h00, 8'h00);
        drive_unit(1, 1'b1, 8'hF0, 8'h0F);
        tick;
        check_unit(1, "w8_f0_0f");
        chk("w8_f0_0f.xor_lit", 64'(x8), 64'hFF);
        chk("w8_f0_0f.cnt_lit", 64'(c8), 64'd8);
        chk("w8_f0_0f.eq_lit",  64'(e8), 64'd0);
        for (int i = 0; i < 3; i++) begin
            drive_unit(1, 1'b0, 8'hxx, 8'hxx);
            tick;
            check_unit(1, $sformatf("w8_hold%0d", i));
            chk($sformatf("w8_hold%0d.cnt_lit", i), 64'(c8), 64'd8);
        end

        drive_unit(1, 1'b1, 8'hA5, 8'hA5);
        tick;
        check_unit(1, "w8_a5_a5");
        chk("w8_a5_a5.eq_lit",  64'(e8), 64'd1);
        chk("w8_a5_a5.cnt_lit", 64'(c8), 64'd0);

        // Mid-stream reset with valid input asserted.
        rst = 1'b1;
        drive_unit(0, 1'b1, 8'h01, 8'h00);
        drive_unit(1, 1'b1, 8'h3C, 8'h00);
        tick;
        check_unit(0, "midrst_w1");
        check_unit(1, "midrst_w8");
        rst = 1'b0;

        for (int i = 0; i < 10000; i++) begin
            drive_unit(0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            drive_unit(1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            tick;
            check_unit(0, "rand_w1");
            check_unit(1, "rand_w8");
        end

        drive_unit(0, 1'b0, 8'h00, 8'h00);
        drive_unit(1, 1'b0, 8'h00, 8'h00);
        tick;
        check_unit(0, "drain_w1");
        check_unit(1, "drain_w8");
        chk("drain_w1.qdepth", 64'(q[0].size()), 64'd0);
        chk("drain_w8.qdepth", 64'(q[1].size()), 64'd0);

`ifdef XOR_DECODER_PARITY_EN
        begin
            logic [3:0] pa [3];
            logic       pe [3];
            pa = '{4'h1, 4'h3, 4'h7};
            pe = '{1'b1, 1'b1, 1'b0};
            for (int i = 0; i < 3; i++) begin
                v4 = 1'b1; a4 = pa[i]; b4 = 4'h0; clr4 = 1'b0;
                tick;
                chk($sformatf("w4_par%0d", i), 64'(p4), 64'(pe[i]));
            end
            v4 = 1'b1; a4 = 4'h1; b4 = 4'h0;
            tick;
            chk("w4_par_set", 64'(p4), 64'd1);
            v4 = 1'b1; a4 = 4'h1; b4 = 4'h0; clr4 = 1'b1;
            tick;
            chk("w4_par_clr", 64'(p4), 64'd0);
            chk("w4_clr_xor", 64'(x4), 64'h1);
            v4 = 1'b0; clr4 = 1'b0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
